// File: rtl/cmpx_acc_pkg.sv
// Shared types and default sizes for the complex accumulator.
package cmpx_acc_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default widths: 16 full-scale terms need 4 guard bits above the product
  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  // Counter/target width, wide enough to hold the value 16
  localparam int CNT_W = 5;

  // Decode the term-count input; zero stands for sixteen terms
  function automatic logic [CNT_W-1:0] decode_terms(input logic [3:0] n);
    decode_terms = (n == 4'd0) ? CNT_W'(16) : CNT_W'(n);
  endfunction

endpackage

// File: rtl/cmpx_acc_lane.sv
// One accumulator lane: sign-extends a product half and adds it into an
// ACC_W-bit register with synchronous clear and load.
module cmpx_acc_lane #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_ext;

  // Next accumulator value: clear wins over load; wrap-around on overflow
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){prod_i[PROD_W-1]}}, prod_i};
    acc_d    = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // Accumulator register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cmpx_accumulator.sv
// Complex multiply-accumulate back end: requests n_terms products from an
// upstream multiplier one at a time and sums real and imaginary halves
// independently.
module cmpx_accumulator
  import cmpx_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          n_terms,
  input  logic [2*PROD_W-1:0] prod_in,
  input  logic                prod_valid,
  output logic                next_req,
  output logic [2*ACC_W-1:0]  acc_out,
  output logic                busy,
  output logic                done
);

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] target_q;
  logic             acc_clr;
  logic             acc_load;

  assign count_d  = count_q + CNT_W'(1);
  // A start only acts in IDLE, and a product is only absorbed in WAIT, so a
  // coincident start/prod_valid in IDLE clears without adding.
  assign acc_clr  = (state_q == IDLE) && start;
  assign acc_load = (state_q == WAIT) && prod_valid;

  // Controller: state, term counter and latched target
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            target_q <= decode_terms(n_terms);
            count_q  <= '0;
            state_q  <= REQ;
          end
        end
        REQ: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (prod_valid) begin
            count_q <= count_d;
            state_q <= (count_d == target_q) ? DONE : REQ;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state
  assign next_req = (state_q == REQ);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);

  // Lane 0 carries the imaginary half (low bits), lane 1 the real half
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      cmpx_acc_lane #(
        .PROD_W(PROD_W),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .load_i(acc_load),
        .prod_i(prod_in[gi*PROD_W +: PROD_W]),
        .acc_o (acc_out[gi*ACC_W +: ACC_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cmpx_accumulator.sv
// Scoreboard bench for cmpx_accumulator: the stimulus task pushes the
// expected sum before each run; the monitor pops and compares on done.
module tb_cmpx_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  n_terms;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        next_req;
  logic [23:0] acc_out;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_errors = 0;
  int          req_seen = 0;
  logic [23:0] exp_q[$];
  logic [15:0] prods[16];

  cmpx_accumulator #(.PROD_W(8), .ACC_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_terms   (n_terms),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .next_req  (next_req),
    .acc_out   (acc_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: count request pulses, score each done against the queue
  always @(negedge clk) begin
    if (next_req === 1'b1) req_seen++;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 24'd1, 24'd0);
      end else begin
        check("sum_at_done", acc_out, exp_q.pop_front());
      end
    end
  end

  // One accumulation. junk: coincident start+prod_valid in IDLE, and
  // prod_valid + start pulses in REQ. abort_at>0: reset in WAIT after that
  // many products have been delivered.
  task automatic run_acc(input string tag, input logic [3:0] nt, input int nprod,
                         input logic [23:0] exp, input bit junk, input int abort_at);
    int got;
    int budget;
    if (abort_at == 0) exp_q.push_back(exp);
    req_seen = 0;
    n_terms  = nt;
    start    = 1'b1;
    if (junk) begin
      prod_valid = 1'b1;
      prod_in    = 16'h7F7F;
    end
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b0;
    got = 0;
    while (got < nprod) begin
      budget = 0;
      while (next_req !== 1'b1 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (next_req !== 1'b1) begin
        check({tag, "_req_timeout"}, 24'd0, 24'd1);
        return;
      end
      if (junk) begin
        prod_valid = 1'b1;
        prod_in    = 16'h7F7F;
        start      = 1'b1;
        n_terms    = 4'd1;
      end
      @(negedge clk);
      start = 1'b0;
      if (abort_at != 0 && got == abort_at) begin
        rst        = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 16'h1111;
        @(negedge clk);
        prod_valid = 1'b0;
        check({tag, "_abort_busy"}, 24'(busy), 24'd0);
        check({tag, "_abort_acc"}, acc_out, 24'h000000);
        check({tag, "_abort_done"}, 24'(done), 24'd0);
        check({tag, "_abort_req"}, 24'(next_req), 24'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_abort_idle"}, 24'(busy), 24'd0);
        return;
      end
      prod_valid = 1'b1;
      prod_in    = prods[got];
      got++;
      @(negedge clk);
      prod_valid = 1'b0;
    end
    check({tag, "_done_latency"}, 24'(done), 24'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 24'(busy), 24'd0);
    repeat (3) @(negedge clk);
    check({tag, "_req_pulses"}, 24'(req_seen), 24'(nprod));
    check({tag, "_hold"}, acc_out, exp);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    n_terms    = 4'd0;
    prod_in    = 16'h0;
    prod_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 24'(busy), 24'd0);
    check("rst_done", 24'(done), 24'd0);
    check("rst_req", 24'(next_req), 24'd0);
    check("rst_acc", acc_out, 24'h000000);
    prod_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);

    // Single term: re=5, im=-3
    prods[0] = 16'h05FD;
    run_acc("t1", 4'd1, 1, 24'h005FFD, 1'b0, 0);

    // Three terms: (1,2)+(-4,7)+(10,-1) = (7,8)
    prods[0] = 16'h0102;
    prods[1] = 16'hFC07;
    prods[2] = 16'h0AFF;
    run_acc("t2", 4'd3, 3, 24'h007008, 1'b0, 0);

    // n_terms=0 means 16 terms of full-scale negative: (-2048,-2048)
    for (int i = 0; i < 16; i++) prods[i] = 16'h8080;
    run_acc("t3", 4'd0, 16, 24'h800800, 1'b0, 0);

    // Stray prod_valid in IDLE must not disturb the held sum
    prod_valid = 1'b1;
    prod_in    = 16'h3344;
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_acc", acc_out, 24'h800800);
    check("idle_valid_busy", 24'(busy), 24'd0);

    // Junk in IDLE/REQ ignored, target not reloaded: (3,3)+(4,-5) = (7,-2)
    prods[0] = 16'h0303;
    prods[1] = 16'h04FB;
    run_acc("t5", 4'd2, 2, 24'h007FFE, 1'b1, 0);

    // Reset in WAIT after 2 of 4 products: no done, everything cleared
    prods[0] = 16'h0101;
    prods[1] = 16'h0202;
    prods[2] = 16'h0303;
    prods[3] = 16'h0404;
    run_acc("t6", 4'd4, 4, 24'h000000, 1'b0, 2);

    // Fresh run after abort: (5,-6)+(-7,8) = (-2,2)
    prods[0] = 16'h05FA;
    prods[1] = 16'hF908;
    run_acc("t7", 4'd2, 2, 24'hFFE002, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
